// File: rtl/conv_z_streamer.sv
// conv_z_streamer: reads the Z result RAM word by word and streams it out
// over a valid/ready interface, low half first, then high half.
// Build option: define CONV_ZSTREAM_SAT_EN to emit one beat per word, each
// beat being the signed 2*DATA_WIDTH word saturated to signed DATA_WIDTH.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; sizes latched on an accepted start
// READ    | present word index k on memZ_addr, arm the RAM latency timer
// WAIT    | wait out the RAM read latency, then capture dataZ into hold
// SEND_LO | offer the low half (or the saturated word) to the sink
// SEND_HI | offer the high half; on transfer advance to the next word
// FINISH  | one-cycle done pulse, busy already low
module conv_z_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     config_in,
   output logic [ADDR_WIDTH:0]       memZ_addr,
   input  logic [2*DATA_WIDTH-1:0]   dataZ,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam int ZW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      WAIT    = 3'd2,
      SEND_LO = 3'd3,
      SEND_HI = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ZW-1:0]           k;
   logic [ZW-1:0]           size_z;
   logic [ZW-1:0]           size_z_calc;
   logic [ZW:0]             k_inc;
   logic [2*DATA_WIDTH-1:0] hold;
   logic                    wait_cnt;
   logic [4:0]              size_x;
   logic [4:0]              size_y;
   logic                    size_zero;
   logic                    last_word;
   logic                    word_done;
   logic                    unused_cfg;

   assign size_x      = config_in[4:0];
   assign size_y      = config_in[9:5];
   assign unused_cfg  = ^config_in[DATA_WIDTH-1:10];
   assign size_zero   = (size_x == 5'd0) || (size_y == 5'd0);
   assign size_z_calc = ZW'(size_x) + ZW'(size_y) - ZW'(1);
   // k_inc is one bit wider so the compare against size_z never wraps
   assign k_inc       = {1'b0, k} + (ZW+1)'(1);
   assign last_word   = !(k_inc < {1'b0, size_z});

`ifdef CONV_ZSTREAM_SAT_EN
   // Clamp a signed double-width word into signed DATA_WIDTH range.
   function automatic logic [DATA_WIDTH-1:0] sat(input logic [2*DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH:0] top;
      top = v[2*DATA_WIDTH-1:DATA_WIDTH-1];
      if ((top == {(DATA_WIDTH+1){1'b0}}) || (top == {(DATA_WIDTH+1){1'b1}}))
         return v[DATA_WIDTH-1:0];
      else if (v[2*DATA_WIDTH-1])
         return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         return {1'b0, {(DATA_WIDTH-1){1'b1}}};
   endfunction
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and output decode; outputs depend only on state and hold,
   // so they stay frozen while the sink stalls.
   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      word_done  = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_next = size_zero ? FINISH : READ;
         end
         READ: begin
            busy       = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (!wait_cnt)
               state_next = SEND_LO;
         end
         SEND_LO: begin
            busy      = 1'b1;
            out_valid = 1'b1;
`ifdef CONV_ZSTREAM_SAT_EN
            out_data  = sat(hold);
            out_last  = last_word;
            if (out_ready) begin
               word_done  = 1'b1;
               state_next = last_word ? FINISH : READ;
            end
`else
            out_data  = hold[DATA_WIDTH-1:0];
            if (out_ready)
               state_next = SEND_HI;
`endif
         end
         SEND_HI: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = hold[2*DATA_WIDTH-1:DATA_WIDTH];
            out_last  = last_word;
            if (out_ready) begin
               word_done  = 1'b1;
               state_next = last_word ? FINISH : READ;
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: size latch, word index, RAM address, latency timer, hold.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         k         <= '0;
         size_z    <= '0;
         memZ_addr <= '0;
         hold      <= '0;
         wait_cnt  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  size_z <= size_zero ? '0 : size_z_calc;
                  k      <= '0;
               end
            end
            READ: begin
               memZ_addr <= k;
               wait_cnt  <= 1'b1;
            end
            WAIT: begin
               if (wait_cnt)
                  wait_cnt <= 1'b0;
               else
                  hold <= dataZ;
            end
            default: ;
         endcase
         if (word_done)
            k <= k_inc[ZW-1:0];
      end
   end

endmodule

// File: tb/tb_conv_z_streamer.sv
// Directed bench for conv_z_streamer: reset, full runs with and without
// sink stalls, empty runs, ignored start, mid-stream reset, saturation.
module tb_conv_z_streamer;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef CONV_ZSTREAM_SAT_EN
   localparam int BPW = 1;
`else
   localparam int BPW = 2;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] config_in = '0;
   logic [AW:0]   memZ_addr;
   logic [2*DW-1:0] dataZ = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;
   logic          done;

   conv_z_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .config_in(config_in),
      .memZ_addr(memZ_addr), .dataZ(dataZ), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Z RAM model: registered read, data one cycle after the address.
   logic [2*DW-1:0] zmem [0:63];
   always @(posedge clk) dataZ <= zmem[memZ_addr];

   int n_cmp = 0;
   int n_fail = 0;

   int nbeats, first_valid, done_cnt, done_cyc, busy_cnt, unstable, last_beat_cyc;
   bit timed_out;
   logic [DW-1:0] beat_data [0:127];
   logic          beat_last [0:127];

   function automatic logic [DW-1:0] exp_beat(input int i);
      logic [2*DW-1:0] w;
`ifdef CONV_ZSTREAM_SAT_EN
      logic signed [2*DW-1:0] s;
      w = zmem[i];
      s = $signed(w);
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return w[31:0];
`else
      w = zmem[i/2];
      return (i % 2 == 0) ? w[31:0] : w[63:32];
`endif
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) zmem[i] = {32'(i), 32'(256 + i)};
   endtask

   task automatic do_start(input int sx, input int sy);
      @(negedge clk);
      config_in = {22'd0, 5'(sy), 5'(sx)};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives out_ready and records everything seen at each falling edge.
   task automatic collect(input int mode, input int max_cyc, input int inject_beat,
                          input int abort_beat);
      bit prev_stall = 1'b0;
      bit injected = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      nbeats = 0; first_valid = -1; done_cnt = 0; done_cyc = -1;
      busy_cnt = 0; unstable = 0; last_beat_cyc = -1; timed_out = 1'b1;
      for (int i = 0; i < 128; i++) begin beat_data[i] = 'x; beat_last[i] = 1'bx; end
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         start = 1'b0;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
            unstable++;
         if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
         if (out_valid === 1'b1 && out_ready) begin
            if (nbeats < 128) begin
               beat_data[nbeats] = out_data;
               beat_last[nbeats] = out_last;
            end
            nbeats++;
            last_beat_cyc = cyc;
         end
         if (inject_beat >= 0 && nbeats == inject_beat && !injected) begin
            start = 1'b1;
            config_in = 32'h21;
            injected = 1'b1;
         end
         if (abort_beat >= 0 && nbeats == abort_beat) begin
            timed_out = 1'b0;
            return;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            timed_out = 1'b0;
            out_ready = 1'b0;
            return;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (memZ_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr got %0h want 0", memZ_addr); end
      n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rst_data got %0h want 0", out_data); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
      n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b want 0", out_last); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      int nl;
      fill_ramp();
      do_start(5, 10);
      collect(0, 400, -1, -1);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
      n_cmp++; if (first_valid !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", first_valid); end
      n_cmp++; if (nbeats !== 14*BPW) begin n_fail++; $display("FAIL basic_nbeats got %0d want %0d", nbeats, 14*BPW); end
      nl = 0;
      for (int i = 0; i < 14*BPW; i++) begin
         n_cmp++;
         if (beat_data[i] !== exp_beat(i)) begin
            n_fail++; $display("FAIL basic_beat%0d got %0h want %0h", i, beat_data[i], exp_beat(i));
         end
         if (beat_last[i] === 1'b1) nl++;
      end
      n_cmp++; if (beat_last[14*BPW-1] !== 1'b1 || nl != 1) begin
         n_fail++; $display("FAIL basic_last got final=%b count=%0d want 1/1", beat_last[14*BPW-1], nl); end
      n_cmp++; if (done_cnt !== 1 || done_cyc !== last_beat_cyc + 1) begin
         n_fail++; $display("FAIL basic_done got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, last_beat_cyc + 1); end
      n_cmp++; if (memZ_addr !== 6'd13) begin n_fail++; $display("FAIL basic_addr_hold got %0d want 13", memZ_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
   endtask

   task automatic test_stall();
      int bad;
      fill_ramp();
      do_start(5, 10);
      collect(1, 600, -1, -1);
      n_cmp++; if (nbeats !== 14*BPW) begin n_fail++; $display("FAIL stall_nbeats got %0d want %0d", nbeats, 14*BPW); end
      bad = 0;
      for (int i = 0; i < 14*BPW; i++) if (beat_data[i] !== exp_beat(i)) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stall_data got %0d bad beats want 0", bad); end
      n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
      n_cmp++; if (beat_last[14*BPW-1] !== 1'b1) begin n_fail++; $display("FAIL stall_last got %b want 1", beat_last[14*BPW-1]); end
      n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero();
      do_start(0, 7);
      collect(0, 20, -1, -1);
      n_cmp++; if (first_valid !== -1 || nbeats !== 0) begin
         n_fail++; $display("FAIL zero_valid got first=%0d beats=%0d want -1/0", first_valid, nbeats); end
      n_cmp++; if (done_cyc < 0 || done_cyc > 1 || done_cnt != 1) begin
         n_fail++; $display("FAIL zero_done got cyc=%0d cnt=%0d want <=1/1", done_cyc, done_cnt); end
      n_cmp++; if (busy_cnt > 1) begin n_fail++; $display("FAIL zero_busy got %0d want <=1", busy_cnt); end
      do_start(6, 0);
      collect(0, 20, -1, -1);
      n_cmp++; if (nbeats !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL zero_y_run got beats=%0d done=%0d want 0/1", nbeats, done_cnt); end
   endtask

   task automatic test_ignore_start();
      int bad;
      fill_ramp();
      do_start(5, 10);
      collect(0, 400, 5, -1);
      bad = 0;
      for (int i = 0; i < 14*BPW; i++) if (beat_data[i] !== exp_beat(i)) bad++;
      n_cmp++; if (nbeats !== 14*BPW || bad != 0) begin
         n_fail++; $display("FAIL ign_run got beats=%0d bad=%0d want %0d/0", nbeats, bad, 14*BPW); end
      n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done got %0d want 1", done_cnt); end
      do_start(2, 2);
      collect(0, 200, -1, -1);
      n_cmp++; if (nbeats !== 3*BPW) begin n_fail++; $display("FAIL restart_nbeats got %0d want %0d", nbeats, 3*BPW); end
      n_cmp++; if (beat_data[0] !== exp_beat(0)) begin
         n_fail++; $display("FAIL restart_first got %0h want %0h", beat_data[0], exp_beat(0)); end
      n_cmp++; if (beat_last[3*BPW-1] !== 1'b1) begin n_fail++; $display("FAIL restart_last got %b want 1", beat_last[3*BPW-1]); end
   endtask

   task automatic test_reset_mid();
      fill_ramp();
      do_start(5, 10);
      collect(0, 400, -1, 9);
      n_cmp++; if (timed_out || done_cnt != 0) begin
         n_fail++; $display("FAIL mid_reach got timeout=%b done=%0d want 0/0", timed_out, done_cnt); end
      rstn = 1'b0;
      @(negedge clk);
      n_cmp++; if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 32'd0 || memZ_addr !== 6'd0) begin
         n_fail++; $display("FAIL mid_outputs got v=%b l=%b b=%b d=%b data=%0h addr=%0d want all 0",
                            out_valid, out_last, busy, done, out_data, memZ_addr); end
      rstn = 1'b1;
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_nodone got %b want 0", done); end
      do_start(1, 1);
      collect(0, 100, -1, -1);
      n_cmp++; if (nbeats !== BPW) begin n_fail++; $display("FAIL mid_restart_nbeats got %0d want %0d", nbeats, BPW); end
      for (int i = 0; i < BPW; i++) begin
         n_cmp++;
         if (beat_data[i] !== exp_beat(i)) begin
            n_fail++; $display("FAIL mid_restart_beat%0d got %0h want %0h", i, beat_data[i], exp_beat(i)); end
      end
      n_cmp++; if (beat_last[BPW-1] !== 1'b1 || memZ_addr !== 6'd0) begin
         n_fail++; $display("FAIL mid_restart_tail got last=%b addr=%0d want 1/0", beat_last[BPW-1], memZ_addr); end
   endtask

`ifdef CONV_ZSTREAM_SAT_EN
   task automatic test_sat();
      logic [DW-1:0] want [0:2];
      want[0] = 32'h7FFF_FFFF; want[1] = 32'hFFFF_FFFE; want[2] = 32'h8000_0000;
      zmem[0] = 64'h0000_0001_0000_0000;
      zmem[1] = 64'hFFFF_FFFF_FFFF_FFFE;
      zmem[2] = 64'hFFFF_FFFF_0000_0000;
      do_start(2, 2);
      collect(0, 100, -1, -1);
      n_cmp++; if (nbeats !== 3) begin n_fail++; $display("FAIL sat_nbeats got %0d want 3", nbeats); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (beat_data[i] !== want[i]) begin
            n_fail++; $display("FAIL sat_beat%0d got %0h want %0h", i, beat_data[i], want[i]); end
      end
      n_cmp++; if (beat_last[2] !== 1'b1 || beat_last[0] !== 1'b0 || beat_last[1] !== 1'b0) begin
         n_fail++; $display("FAIL sat_last got %b%b%b want 001", beat_last[0], beat_last[1], beat_last[2]); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_ignore_start();
      test_reset_mid();
`ifdef CONV_ZSTREAM_SAT_EN
      test_sat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_z_streamer.md
CONV_Z_STREAMER -- requirements
Module: conv_z_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width of X/Y operands and of the output stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, operand address width; the Z address is ADDR_WIDTH+1 bits.
REQ-003 SHALL use one clock and a synchronous active-low reset; ports clk and rstn.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 start  input  1  one-cycle request to stream the result memory.
REQ-007 config_in  input  DATA_WIDTH  [4:0]=sizeX, [9:5]=sizeY; other bits ignored.
REQ-008 memZ_addr  output  ADDR_WIDTH+1  read address to the Z RAM.
REQ-009 dataZ  input  2*DATA_WIDTH  Z RAM read data; valid one cycle after memZ_addr is presented.
REQ-010 out_data  output  DATA_WIDTH  stream payload.
REQ-011 out_valid  output  1  payload valid.
REQ-012 out_ready  input  1  sink accepts; transfer when out_valid and out_ready are both high at a rising edge.
REQ-013 out_last  output  1  marks the final beat.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, SEND_LO, SEND_HI, FINISH.
REQ-017 In IDLE, start=1 SHALL latch sizeZ = sizeX+sizeY-1 (ADDR_WIDTH+1 bits, no overflow), clear word index k, and go to READ.
REQ-018 If sizeX==0 or sizeY==0 at start, SHALL go directly to FINISH with no beats emitted.
REQ-019 READ SHALL drive memZ_addr=k for one cycle, then go to WAIT.
REQ-020 WAIT SHALL register dataZ into a 64-bit hold register, then go to SEND_LO with out_valid=1.
REQ-021 The first out_valid SHALL rise on the 3rd rising edge after the edge that samples start.
REQ-022 SEND_LO SHALL present hold[DATA_WIDTH-1:0]; on transfer, go to SEND_HI.
REQ-023 SEND_HI SHALL present hold[2*DATA_WIDTH-1:DATA_WIDTH]; on transfer, increment k and go to READ if k+1<sizeZ, else FINISH.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL remain stable.
REQ-025 out_last SHALL be 1 only during the final beat of the final word.
REQ-026 FINISH SHALL assert done for exactly one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-027 start while not in IDLE SHALL be ignored; config_in SHALL only be sampled at accepted start.
REQ-028 memZ_addr SHALL hold its last value outside READ.

Reset
REQ-029 With rstn=0 at a rising edge: state=IDLE, k=0, sizeZ=0, memZ_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-030 Reset mid-stream SHALL abort immediately, without done or out_last; the next start SHALL restart from k=0.

Configuration
REQ-031 Macro CONV_ZSTREAM_SAT_EN selects the output format.
REQ-032 With CONV_ZSTREAM_SAT_EN undefined, each Z word SHALL be emitted as two beats, low then high (2*sizeZ beats total).
REQ-033 With CONV_ZSTREAM_SAT_EN defined, SEND_HI SHALL be skipped; each word SHALL be emitted as one beat of its signed 64-bit value saturated to signed DATA_WIDTH (0x7FFFFFFF / 0x80000000 at the limits); after that beat, advance k as REQ-023 (sizeZ beats total, out_last on the single final beat).

Verification
REQ-034 sizeX=5, sizeY=10, out_ready=1, Z[k]={32'k,32'h100+k} -> 28 beats, h100,0,h101,1,...,h10D,13; out_last on beat 28; done 1 cycle later.
REQ-035 Same as REQ-034 with out_ready toggled 1/0 every cycle -> identical beat sequence, payload stable on stalled cycles, no lost or duplicated beats.
REQ-036 sizeX=0, sizeY=7 -> no out_valid; done pulses within 2 cycles of start; busy high at most 1 cycle.
REQ-037 Start at beat 5 of a 14-word run -> ignored; run completes normally; a second start after done -> full restart from address 0.
REQ-038 rstn=0 for 1 cycle at beat 9 -> all outputs 0 next cycle; no done; a new start (sizeX=1, sizeY=1) -> 2 beats from address 0.
REQ-039 SAT_EN defined, Z={64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_0000_0000}, sizeX=2, sizeY=2 -> beats 0x7FFFFFFF, 0xFFFFFFFE, 0x80000000; out_last on the 3rd beat.
